// File: rtl/sevenseg_pkg.sv
// Shared types, glyph constants and the hex-to-segment decoder for the
// multiplexed 7-segment display path.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// done is high in the cycle whose closing edge performs the final shift.
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_BCD  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_BCD-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [4*N_BCD-1:0]  acc_q, acc_d, adj_s;

  assign done = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign busy = busy_q;
  assign bcd  = acc_q;

  always_comb begin
    adj_s = acc_q;
    for (int i = 0; i < N_BCD; i++) begin
      adj_s[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? (acc_q[4*i +: 4] + 4'd3)
                                                  : acc_q[4*i +: 4];
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    acc_d  = acc_q;
    if (busy_q) begin
      acc_d  = {adj_s[4*N_BCD-2:0], sh_q[DATA_W-1]};
      sh_d   = sh_q << 1;
      cnt_d  = cnt_q + CNT_W'(1);
      busy_d = !done;
    end else if (start) begin
      acc_d  = '0;
      sh_d   = bin;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// N-digit multiplexed 7-segment driver: latches a value in hex or decimal,
// scans digits with registered Segments/Anodes, blanks leading zeros.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   value,
  input  logic                load,
  input  logic                dec_mode,
  input  logic                blank_lz,
  output logic                busy,
  output logic                ovf,
  output logic [6:0]          Segments,
  output logic [N_DIGITS-1:0] Anodes
);

  localparam int N_BCD  = (DATA_W * 30103 + 99999) / 100000;
  localparam int DISP_W = 4 * N_DIGITS;
  localparam int BCD_W  = 4 * N_BCD;
  localparam int PAD_W  = (BCD_W > DISP_W) ? BCD_W : DISP_W;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (DATA_W > 4 * N_DIGITS) begin : g_bad_width
    $error("sevenseg_scan_driver: DATA_W exceeds 4*N_DIGITS");
  end
  if (N_DIGITS < 1 || REFRESH_DIV < 1) begin : g_bad_param
    $error("sevenseg_scan_driver: N_DIGITS and REFRESH_DIV must be >= 1");
  end

  state_t               state_q, state_d;
  logic [DISP_W-1:0]    disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic [IDX_W-1:0]     idx_q, idx_d, msd_s;
  logic [RCNT_W-1:0]    rcnt_q, rcnt_d;
  logic [6:0]           seg_q, glyph_s;
  logic [N_DIGITS-1:0]  an_q;
  logic [3:0]           nib_s;
  logic                 start_s, cv_busy_s, cv_done_s, bcd_ovf_s;
  logic [BCD_W-1:0]     bcd_s;
  logic [PAD_W-1:0]     bcd_pad_s;

  bin2bcd_seq #(.DATA_W(DATA_W), .N_BCD(N_BCD)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .bin   (value),
    .busy  (cv_busy_s),
    .done  (cv_done_s),
    .bcd   (bcd_s)
  );

  // Any nonzero BCD digit beyond the display width means the value does not fit.
  assign bcd_pad_s = PAD_W'(bcd_s);
  assign bcd_ovf_s = |(bcd_pad_s >> DISP_W);

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (load && dec_mode) begin
          start_s = 1'b1;
          state_d = CONV;
        end else if (load) begin
          disp_d = DISP_W'(value);
          ovf_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CONV:    state_d = (cv_done_s || !cv_busy_s) ? DONE : CONV;
      DONE: begin
        disp_d  = bcd_pad_s[DISP_W-1:0];
        ovf_d   = bcd_ovf_s;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : (idx_q + IDX_W'(1));
    end else begin
      idx_d  = idx_q;
    end
  end

  always_comb begin
    msd_s = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      msd_s = (disp_q[4*i +: 4] != 4'd0) ? IDX_W'(i) : msd_s;
    end
  end

  // Dashes take priority over blanking; digit 0 is never above the msd.
  always_comb begin
    nib_s = disp_q[4*idx_q +: 4];
    if (ovf_q) begin
      glyph_s = SEG_DASH;
    end else if (blank_lz && (idx_q > msd_s)) begin
      glyph_s = SEG_BLANK;
    end else begin
      glyph_s = hex_to_seg(nib_s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      rcnt_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
      seg_q   <= glyph_s;
      an_q    <= ~(N_DIGITS'(1) << idx_q);
    end
  end

  assign busy     = (state_q != IDLE);
  assign ovf      = ovf_q;
  assign Segments = seg_q;
  assign Anodes   = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver: an 8-digit and a 4-digit instance
// share stimulus; segment glyphs are rebuilt from lit-segment letter lists.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset, load, dec_mode, blank_lz;
  logic [15:0] value;
  logic        busy8, ovf8, busy4, ovf4;
  logic [6:0]  seg8, seg4;
  logic [7:0]  an8;
  logic [3:0]  an4;
  logic [6:0]  got_seg [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          scan_live = 1'b0;
  int          cnt;
  int          act;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(.N_DIGITS(8), .DATA_W(16), .REFRESH_DIV(2)) dut8 (
    .clk(clk), .reset(reset), .value(value), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .busy(busy8), .ovf(ovf8), .Segments(seg8), .Anodes(an8));

  sevenseg_scan_driver #(.N_DIGITS(4), .DATA_W(16), .REFRESH_DIV(2)) dut4 (
    .clk(clk), .reset(reset), .value(value), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .busy(busy4), .ovf(ovf4), .Segments(seg4), .Anodes(an4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] lit(input string s);
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return lit("abcdef");
      4'h1: return lit("bc");
      4'h2: return lit("abdeg");
      4'h3: return lit("abcdg");
      4'h4: return lit("bcfg");
      4'h5: return lit("acdfg");
      4'h6: return lit("acdefg");
      4'h7: return lit("abc");
      4'h8: return lit("abcdefg");
      4'h9: return lit("abcdfg");
      4'hA: return lit("abcefg");
      4'hB: return lit("cdefg");
      4'hC: return lit("adef");
      4'hD: return lit("bcdeg");
      4'hE: return lit("adefg");
      default: return lit("aefg");
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input bit dec);
    value = v; dec_mode = dec; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Walks a little more than one full scan period; later samples overwrite earlier ones.
  task automatic scan(input bit use4);
    for (int i = 0; i < 8; i++) got_seg[i] = 'x;
    repeat (18) begin
      tick();
      for (int i = 0; i < 8; i++) begin
        if (!use4 && an8 == ~(8'b1 << i)) got_seg[i] = seg8;
        if (use4 && i < 4 && an4 == ~(4'b1 << i)) got_seg[i] = seg4;
      end
    end
  endtask

  task automatic expect_digits(input string tag, input int nd, input logic [31:0] nibs,
                               input logic [7:0] blank_mask);
    for (int i = 0; i < nd; i++)
      check($sformatf("%s d%0d", tag, i), 32'(got_seg[i]),
            blank_mask[i] ? 32'h7F : 32'(glyph(nibs[4*i +: 4])));
  endtask

  task automatic count_busy(input bit use4, output int c);
    c = 0;
    while ((use4 ? busy4 : busy8) && c < 100) begin
      c++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (scan_live) begin
      check("onehot8", 32'($onehot(~an8)), 32'd1);
      check("onehot4", 32'($onehot(~an4)), 32'd1);
    end
  end

  initial begin
    reset = 1'b1; load = 1'b0; dec_mode = 1'b0; blank_lz = 1'b0; value = 16'h0;

    // T1: reset state and scan start
    repeat (4) begin
      tick();
      check("T1 rst an8", 32'(an8), 32'hFF);
      check("T1 rst seg8", 32'(seg8), 32'h7F);
      check("T1 rst busy", 32'(busy8), 32'd0);
      check("T1 rst ovf", 32'(ovf8), 32'd0);
    end
    reset = 1'b0;
    tick(); scan_live = 1'b1;
    check("T1 an8 c0", 32'(an8), 32'hFE);
    check("T1 an4 c0", 32'(an4), 32'hE);
    tick(); check("T1 an8 c1", 32'(an8), 32'hFE);
    tick(); check("T1 an8 c2", 32'(an8), 32'hFD);
    scan(1'b0); expect_digits("T1 disp", 8, 32'h0, 8'h00);

    // T2: hex load
    do_load(16'hBEEF, 1'b0);
    check("T2 busy", 32'(busy8), 32'd0);
    scan(1'b0);
    check("T2 busy late", 32'(busy8), 32'd0);
    expect_digits("T2 hex", 8, 32'h0000BEEF, 8'h00);
    blank_lz = 1'b1; scan(1'b0); expect_digits("T2 hex lz", 8, 32'h0000BEEF, 8'hF0);
    blank_lz = 1'b0;

    // T3: decimal 65535
    do_load(16'd65535, 1'b1);
    count_busy(1'b0, cnt);
    check("T3 busy cycles", 32'(cnt), 32'd17);
    check("T3 ovf", 32'(ovf8), 32'd0);
    scan(1'b0); expect_digits("T3 dec", 8, 32'h00065535, 8'h00);
    blank_lz = 1'b1; scan(1'b0); expect_digits("T3 dec lz", 8, 32'h00065535, 8'hE0);
    blank_lz = 1'b0;

    // T4: load while busy is ignored, old display held during conversion
    do_load(16'd9999, 1'b1);
    tick(); tick();
    do_load(16'd1234, 1'b1);
    cnt = 0;
    while (busy8 && cnt < 100) begin
      act = 0;
      for (int i = 0; i < 8; i++) if (an8 == ~(8'b1 << i)) act = i;
      check("T4 hold", 32'(seg8), 32'(glyph(4'(32'h00065535 >> (4 * act)))));
      cnt++;
      tick();
    end
    check("T4 busy tail", 32'(cnt), 32'd14);
    scan(1'b0); expect_digits("T4 dec", 8, 32'h00009999, 8'h00);

    // T5: decimal overflow on the 4-digit instance, then recovery by hex load
    do_load(16'd12345, 1'b1);
    count_busy(1'b1, cnt);
    check("T5 busy cycles", 32'(cnt), 32'd17);
    check("T5 ovf4", 32'(ovf4), 32'd1);
    check("T5 ovf8", 32'(ovf8), 32'd0);
    blank_lz = 1'b1; scan(1'b1);
    for (int i = 0; i < 4; i++) check($sformatf("T5 dash d%0d", i), 32'(got_seg[i]), 32'h3F);
    blank_lz = 1'b0;
    do_load(16'h0001, 1'b0);
    check("T5 ovf clr", 32'(ovf4), 32'd0);
    scan(1'b1); expect_digits("T5 hex", 4, 32'h0001, 8'h00);

    // T6: reset aborts a conversion; next conversion completes normally
    do_load(16'd500, 1'b1);
    repeat (4) tick();
    scan_live = 1'b0; reset = 1'b1;
    tick();
    check("T6 rst busy", 32'(busy8), 32'd0);
    check("T6 rst an8", 32'(an8), 32'hFF);
    reset = 1'b0;
    tick(); scan_live = 1'b1;
    scan(1'b0);
    check("T6 busy idle", 32'(busy8), 32'd0);
    expect_digits("T6 cleared", 8, 32'h0, 8'h00);
    do_load(16'd42, 1'b1);
    count_busy(1'b0, cnt);
    check("T6 busy cycles", 32'(cnt), 32'd17);
    scan(1'b0); expect_digits("T6 dec", 8, 32'h42, 8'h00);
    blank_lz = 1'b1; scan(1'b0); expect_digits("T6 dec lz", 8, 32'h42, 8'hFC);
    blank_lz = 1'b0;

    scan_live = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
